uart_reg_arbiter: RTL

- Shares the single register port of the UART controller (`reg_write`/`reg_read`/`reg_addr`/`reg_wdata`/`reg_rdata`/`reg_ready`) between `NUM_REQ` requesters, e.g. the AXI-Lite bridge and a DMA/descriptor engine.
- Grants with a rotating (round-robin) priority and runs exactly one register access at a time.
- Holds the strobe until the controller returns `reg_ready`, then returns the read data to the granted requester.
- A watchdog ends any access the controller never acknowledges.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_reg_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-port arbiter: bus widths, the
// timeout read pattern and the arbiter FSM state type.
package uart_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// grant and wraps, so the most recently served requester is tried last.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path
        // through this block leaves a signal unassigned and infers a latch.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = 1; off <= N; off++) begin
            cand     = (int'(last_grant_i) + off) % N;
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_reg_arbiter.sv
// Shares the UART controller register port between NUM_REQ requesters with
// round-robin grants, one access at a time, and a watchdog for lost acks.
module uart_reg_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*REG_DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [REG_DATA_W-1:0]        resp_rdata,
    output logic                         resp_error,
    output logic                         reg_write,
    output logic                         reg_read,
    output logic [REG_ADDR_W-1:0]        reg_addr,
    output logic [REG_DATA_W-1:0]        reg_wdata,
    input  logic [REG_DATA_W-1:0]        reg_rdata,
    input  logic                         reg_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t              state_q;
    logic [IDX_W-1:0]        last_grant_q;
    logic [NUM_REQ-1:0]      grant_q;
    logic [CNT_W-1:0]        tmo_cnt_q;
    logic                    reg_write_q;
    logic                    reg_read_q;
    logic [REG_ADDR_W-1:0]   reg_addr_q;
    logic [REG_DATA_W-1:0]   reg_wdata_q;
    logic [NUM_REQ-1:0]      resp_valid_q;
    logic [REG_DATA_W-1:0]   resp_rdata_q;
    logic                    resp_error_q;

    logic [NUM_REQ-1:0]      win_oh_d;
    logic [IDX_W-1:0]        win_idx_d;
    logic                    tmo_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (win_oh_d),
        .grant_idx_o  (win_idx_d)
    );

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CNT_LAST);

    // NOTE: the grant is the only combinational output; gating it with reset_n
    // keeps it low while reset is asserted even if requesters are still valid.
    assign req_ready = (state_q == IDLE && reset_n) ? win_oh_d : '0;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            tmo_cnt_q    <= '0;
            reg_write_q  <= 1'b0;
            reg_read_q   <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q      <= win_oh_d;
                        last_grant_q <= win_idx_d;
                        tmo_cnt_q    <= '0;
                        reg_write_q  <= req_write[win_idx_d];
                        reg_read_q   <= !req_write[win_idx_d];
                        reg_addr_q   <= req_addr[win_idx_d*REG_ADDR_W +: REG_ADDR_W];
                        reg_wdata_q  <= req_wdata[win_idx_d*REG_DATA_W +: REG_DATA_W];
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // An acknowledge in the same cycle as the limit still counts as success.
                    if (reg_ready) begin
                        resp_rdata_q <= reg_rdata;
                        resp_error_q <= 1'b0;
                        resp_valid_q <= grant_q;
                        reg_write_q  <= 1'b0;
                        reg_read_q   <= 1'b0;
                        state_q      <= RESP;
                    end else if (tmo_hit) begin
                        resp_rdata_q <= TIMEOUT_RDATA;
                        resp_error_q <= 1'b1;
                        resp_valid_q <= grant_q;
                        reg_write_q  <= 1'b0;
                        reg_read_q   <= 1'b0;
                        state_q      <= RESP;
                    end else if (tmo_cnt_q != CNT_MAX) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid_q <= '0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign reg_write  = reg_write_q;
    assign reg_read   = reg_read_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule
